// File: rtl/packet_tx_sched_if.sv
// Signal bundle between the packet transmit scheduler, its two requesters
// and the packet transmitter. The master modport is the scheduler itself,
// and the slave modport is everything connected around it.
interface packet_tx_sched_if;
    logic        req0_valid;
    logic        req1_valid;
    logic [15:0] req0_len;
    logic [15:0] req1_len;
    logic [7:0]  req0_type;
    logic [7:0]  req1_type;
    logic [31:0] req0_data;
    logic [31:0] req1_data;
    logic        req0_data_rd;
    logic        req1_data_rd;
    logic        req0_done;
    logic        req1_done;
    logic        pkt_req;
    logic [15:0] pkt_len;
    logic [7:0]  pkt_type;
    logic [31:0] pkt_data;
    logic        pkt_data_rd;
    logic        pkt_done;
    logic        grant;
    logic        busy;
    logic [1:0]  err_flags;

    modport master (
        input  req0_valid, req1_valid, req0_len, req1_len, req0_type, req1_type,
               req0_data, req1_data, pkt_data_rd, pkt_done,
        output req0_data_rd, req1_data_rd, req0_done, req1_done, pkt_req,
               pkt_len, pkt_type, pkt_data, grant, busy, err_flags
    );

    modport slave (
        output req0_valid, req1_valid, req0_len, req1_len, req0_type, req1_type,
               req0_data, req1_data, pkt_data_rd, pkt_done,
        input  req0_data_rd, req1_data_rd, req0_done, req1_done, pkt_req,
               pkt_len, pkt_type, pkt_data, grant, busy, err_flags
    );
endinterface

// File: rtl/packet_tx_sched.sv
// Two-requester round-robin packet transmit scheduler. It grants one requester
// at a time, hands its packet to the transmitter with a single pkt_req pulse,
// waits for pkt_done (or a timeout), and then enforces an idle gap before the
// next arbitration. Zero-length packets are dropped without involving the
// transmitter.
module packet_tx_sched #(
    parameter int unsigned GAP_CYCLES   = 4,
    parameter int unsigned DONE_TIMEOUT = 4096
) (
    input  logic              tx_clk,
    input  logic              rst_n,
    packet_tx_sched_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DONE,
        GAP
    } state_t;

    // Last value the timeout counter reaches in WAIT_DONE before the packet
    // is abandoned; the gap counter counts down from GAP_LOAD to zero.
    localparam logic [15:0] TIMEOUT_LAST = 16'(DONE_TIMEOUT - 1);
    localparam logic [7:0]  GAP_LOAD     = 8'(GAP_CYCLES - 1);

    state_t      state;
    state_t      next_state;

    logic        grant_q;
    logic        last_grant_q;
    logic [15:0] len_q;
    logic [7:0]  type_q;
    logic [1:0]  err_q;
    logic        done0_q;
    logic        done1_q;
    logic [15:0] to_cnt;
    logic [7:0]  gap_cnt;

    logic        pick;
    logic [15:0] pick_len;
    logic [7:0]  pick_type;
    logic        do_grant;
    logic        finish;
    logic        timed_out;
    logic        busy_c;
    logic        pkt_req_c;

    // Round-robin choice: a lone requester wins, a tie goes to the requester that was not granted last.
    always_comb begin
        pick = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            pick = ~last_grant_q;
        end else if (bus.req1_valid) begin
            pick = 1'b1;
        end
        pick_len  = pick ? bus.req1_len  : bus.req0_len;
        pick_type = pick ? bus.req1_type : bus.req0_type;
    end

    // State register.
    always_ff @(posedge tx_clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the per-cycle control strobes and state-derived outputs.
    always_comb begin
        next_state = state;
        do_grant   = 1'b0;
        finish     = 1'b0;
        timed_out  = 1'b0;
        busy_c     = (state != IDLE);
        pkt_req_c  = (state == REQ);
        case (state)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    do_grant   = 1'b1;
                    next_state = (pick_len == 16'd0) ? GAP : REQ;
                end
            end
            REQ: begin
                next_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A pkt_done arriving in the same cycle as the timeout still counts as completion.
                if (bus.pkt_done) begin
                    finish     = 1'b1;
                    next_state = GAP;
                end else if (to_cnt == TIMEOUT_LAST) begin
                    finish     = 1'b1;
                    timed_out  = 1'b1;
                    next_state = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == 8'd0) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Grant bookkeeping, latched packet header, done pulses, sticky errors and the two counters.
    always_ff @(posedge tx_clk) begin
        if (!rst_n) begin
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            len_q        <= 16'd0;
            type_q       <= 8'd0;
            err_q        <= 2'b00;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            to_cnt       <= 16'd0;
            gap_cnt      <= 8'd0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;

            if (do_grant) begin
                grant_q      <= pick;
                last_grant_q <= pick;
                len_q        <= pick_len;
                type_q       <= pick_type;
                if (pick_len == 16'd0) begin
                    err_q[0] <= 1'b1;
                    if (pick) begin
                        done1_q <= 1'b1;
                    end else begin
                        done0_q <= 1'b1;
                    end
                end
            end

            if (finish) begin
                if (grant_q) begin
                    done1_q <= 1'b1;
                end else begin
                    done0_q <= 1'b1;
                end
                if (timed_out) begin
                    err_q[1] <= 1'b1;
                end
            end

            if (state == REQ) begin
                to_cnt <= 16'd0;
            end else if (state == WAIT_DONE) begin
                to_cnt <= to_cnt + 16'd1;
            end

            if ((next_state == GAP) && (state != GAP)) begin
                gap_cnt <= GAP_LOAD;
            end else if ((state == GAP) && (gap_cnt != 8'd0)) begin
                gap_cnt <= gap_cnt - 8'd1;
            end
        end
    end

    assign bus.grant        = grant_q;
    assign bus.busy         = busy_c;
    assign bus.pkt_req      = pkt_req_c;
    assign bus.pkt_len      = len_q;
    assign bus.pkt_type     = type_q;
    assign bus.err_flags    = err_q;
    assign bus.req0_done    = done0_q;
    assign bus.req1_done    = done1_q;
    assign bus.pkt_data     = grant_q ? bus.req1_data : bus.req0_data;
    assign bus.req0_data_rd = bus.pkt_data_rd && !grant_q && busy_c;
    assign bus.req1_data_rd = bus.pkt_data_rd &&  grant_q && busy_c;

endmodule
